// File: rtl/arcade_clkrst_ctrl_if.sv
// Purpose : Control/status bundle between the hps_io-side glue and the clock/reset
//           controller.
// Signals : reset_req  - OR of all reset sources
//           osd_open   - OSD open; keeps the core in reset once reset has started
//           div_cfg    - requested divisor-minus-1 per channel, ch0 in the LSBs
//           cfg_load   - 1-cycle strobe that captures div_cfg into the shadow registers
//           pause      - pause request
//           pause_mask - 1 = channel frozen while paused
//           ce_out     - registered 1-cycle clock-enable strobes
//           core_reset - registered active-high core reset
//           running    - 1 while the sequencer is in RUN
// Modports: master drives the requests and reads status; slave is the controller.
interface arcade_clkrst_ctrl_if #(
    parameter int unsigned NUM_CE = 4,
    parameter int unsigned DIV_W  = 4
);
    logic                    reset_req;
    logic                    osd_open;
    logic [NUM_CE*DIV_W-1:0] div_cfg;
    logic                    cfg_load;
    logic                    pause;
    logic [NUM_CE-1:0]       pause_mask;
    logic [NUM_CE-1:0]       ce_out;
    logic                    core_reset;
    logic                    running;

    modport master (
        output reset_req, osd_open, div_cfg, cfg_load, pause, pause_mask,
        input  ce_out, core_reset, running
    );

    modport slave (
        input  reset_req, osd_open, div_cfg, cfg_load, pause, pause_mask,
        output ce_out, core_reset, running
    );
endinterface

// File: rtl/arcade_clkrst_ctrl.sv
// Purpose : Reset sequencer and multi-channel clock-enable generator for arcade cores.
//           Stretches core_reset to at least MIN_RST cycles, then aligns all divider
//           phases in a single cycle and produces per-channel CE strobes with runtime
//           divisors and per-channel pause freeze.
// Ports   : i_clk_sys - system clock
//           i_reset_n - asynchronous active-low reset
//           io_bus    - control/status interface (slave side), see arcade_clkrst_ctrl_if
module arcade_clkrst_ctrl #(
    parameter int unsigned             NUM_CE  = 4,
    parameter int unsigned             DIV_W   = 4,
    parameter int unsigned             MIN_RST = 16,
    parameter logic [NUM_CE*DIV_W-1:0] DEF_DIV = 16'h5310
) (
    input  logic                 i_clk_sys,
    input  logic                 i_reset_n,
    arcade_clkrst_ctrl_if.slave  io_bus
);

    localparam int unsigned RCW = (MIN_RST > 1) ? $clog2(MIN_RST) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(MIN_RST - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHold  = 2'd1,
        StAlign = 2'd2
    } state_e;

    state_e                        r_state, w_state_d;
    logic [RCW-1:0]                r_rst_cnt, w_rst_cnt_d;
    logic                          r_core_reset;
    logic                          r_running;
    logic [NUM_CE-1:0]             r_ce, w_ce_d;
    logic [NUM_CE-1:0][DIV_W-1:0]  r_div, w_div_d;
    logic [NUM_CE-1:0][DIV_W-1:0]  r_shadow, w_shadow_d;
    logic [NUM_CE-1:0][DIV_W-1:0]  r_cnt, w_cnt_d;

    // Sequencer next state
    always_comb begin
        w_state_d   = r_state;
        w_rst_cnt_d = r_rst_cnt;
        unique case (r_state)
            StRun: begin
                // osd_open alone never starts a reset
                if (io_bus.reset_req) begin
                    w_state_d   = StHold;
                    w_rst_cnt_d = RST_LOAD;
                end
            end
            StHold: begin
                // Counter saturates at 0; a re-asserted reset_req only extends the wait
                if (r_rst_cnt != '0) begin
                    w_rst_cnt_d = r_rst_cnt - 1'b1;
                end else if (!io_bus.reset_req && !io_bus.osd_open) begin
                    w_state_d = StAlign;
                end
            end
            StAlign: begin
                w_state_d = StRun;
            end
            default: begin
                w_state_d = StHold;
            end
        endcase
    end

    // Dividers, divisor shadowing and strobe generation
    always_comb begin
        w_cnt_d    = r_cnt;
        w_div_d    = r_div;
        w_ce_d     = '0;
        w_shadow_d = io_bus.cfg_load ? io_bus.div_cfg : r_shadow;
        if (r_state == StAlign) begin
            // Common phase origin for every channel
            w_cnt_d = '0;
            w_div_d = r_shadow;
        end else if (r_state == StRun) begin
            for (int k = 0; k < NUM_CE; k++) begin
                if (!(io_bus.pause && io_bus.pause_mask[k])) begin
                    if (r_cnt[k] == r_div[k]) begin
                        // New divisor only at a wrap, so no period is ever truncated.
                        // r_shadow (not w_shadow_d) makes a coincident cfg_load wait
                        // for the following wrap.
                        w_cnt_d[k] = '0;
                        w_div_d[k] = r_shadow[k];
                        w_ce_d[k]  = !io_bus.reset_req;
                    end else begin
                        w_cnt_d[k] = r_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StHold;
            r_rst_cnt    <= RST_LOAD;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_ce         <= '0;
            r_div        <= DEF_DIV;
            r_shadow     <= DEF_DIV;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_d;
            r_rst_cnt    <= w_rst_cnt_d;
            r_core_reset <= (w_state_d != StRun);
            r_running    <= (w_state_d == StRun);
            r_ce         <= w_ce_d;
            r_div        <= w_div_d;
            r_shadow     <= w_shadow_d;
            r_cnt        <= w_cnt_d;
        end
    end

    assign io_bus.ce_out     = r_ce;
    assign io_bus.core_reset = r_core_reset;
    assign io_bus.running    = r_running;

endmodule

// File: tb/tb_arcade_clkrst_ctrl.sv
module tb_arcade_clkrst_ctrl;

    logic clk;
    logic reset_n;

    arcade_clkrst_ctrl_if #(.NUM_CE(4), .DIV_W(4)) bus ();
    arcade_clkrst_ctrl_if #(.NUM_CE(4), .DIV_W(4)) bus1 ();

    arcade_clkrst_ctrl u_dut (
        .i_clk_sys (clk),
        .i_reset_n (reset_n),
        .io_bus    (bus)
    );

    arcade_clkrst_ctrl #(.MIN_RST(1)) u_dut1 (
        .i_clk_sys (clk),
        .i_reset_n (reset_n),
        .io_bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cfg_load;
        logic [15:0] div_cfg;
        logic        pause;
        logic [3:0]  pause_mask;
        logic [3:0]  exp_ce;
    } vec_t;

    vec_t       v [1:40];
    int         n_chk;
    int         n_err;
    int         n_edges;
    int         bad;
    logic [3:0] exp_seq [1:6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ticks until core_reset of the main DUT falls, bounded
    task automatic wait_release(output int n);
        n = 0;
        while (bus.core_reset === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // Vector i: inputs held during RUN cycle i-1, ce_out expected in RUN cycle i
        for (int i = 1; i <= 40; i++) begin
            v[i] = '{1'b0, 16'h0000, 1'b0, 4'b0000, (i % 2 == 1) ? 4'b0001 : 4'b0011};
        end
        v[4].exp_ce  = 4'b0111;
        v[6].exp_ce  = 4'b1011;
        v[8].exp_ce  = 4'b0111;
        v[12].exp_ce = 4'b1111;
        // cfg_load in cycle 13 (cnt2=1): ch2 becomes period 6 after its pulse in 16
        v[14] = '{1'b1, 16'h5510, 1'b0, 4'b0000, 4'b0011};
        v[16].exp_ce = 4'b0111;
        v[18].exp_ce = 4'b1011;
        v[22].exp_ce = 4'b0111;
        v[24].exp_ce = 4'b1011;
        // Pause ch3/ch2 in cycles 26..35 (cnt3=2, cnt2=4); ch1/ch0 keep cadence
        for (int i = 27; i <= 36; i++) begin
            v[i].pause      = 1'b1;
            v[i].pause_mask = 4'b1100;
        end
        v[38].exp_ce = 4'b0111;
        v[40].exp_ce = 4'b1011;

        reset_n         = 1'b0;
        bus.reset_req   = 1'b0;
        bus.osd_open    = 1'b0;
        bus.div_cfg     = '0;
        bus.cfg_load    = 1'b0;
        bus.pause       = 1'b0;
        bus.pause_mask  = '0;
        bus1.reset_req  = 1'b0;
        bus1.osd_open   = 1'b0;
        bus1.div_cfg    = '0;
        bus1.cfg_load   = 1'b0;
        bus1.pause      = 1'b0;
        bus1.pause_mask = '0;

        // Reset state
        tick();
        tick();
        chk("rst_core_reset", bus.core_reset, 1);
        chk("rst_ce", bus.ce_out, 0);
        chk("rst_running", bus.running, 0);

        // Reset stretch: HOLD for MIN_RST cycles plus one ALIGN cycle
        reset_n = 1'b1;
        wait_release(n_edges);
        chk("rst_len", n_edges, 17);
        chk("run0_running", bus.running, 1);
        chk("run0_ce", bus.ce_out, 0);

        // Table: cadence, divisor reload, pause
        for (int i = 1; i <= 40; i++) begin
            bus.cfg_load   = v[i].cfg_load;
            bus.div_cfg    = v[i].div_cfg;
            bus.pause      = v[i].pause;
            bus.pause_mask = v[i].pause_mask;
            tick();
            chk($sformatf("vec%0d_ce", i), bus.ce_out, v[i].exp_ce);
            chk($sformatf("vec%0d_core_reset", i), bus.core_reset, 0);
        end
        bus.cfg_load = 1'b0;
        bus.pause    = 1'b0;

        // One-cycle reset_req while OSD open for 100 cycles
        bus.reset_req = 1'b1;
        bus.osd_open  = 1'b1;
        tick();
        bus.reset_req = 1'b0;
        chk("req_ce_stop", bus.ce_out, 0);
        chk("req_core_reset", bus.core_reset, 1);
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (bus.core_reset !== 1'b1 || bus.ce_out !== 4'b0000 || bus.running !== 1'b0) begin
                bad++;
            end
        end
        chk("osd_hold_bad_cycles", bad, 0);
        bus.osd_open = 1'b0;
        tick();
        chk("align_core_reset", bus.core_reset, 1);
        chk("align_running", bus.running, 0);
        tick();
        chk("rerun_core_reset", bus.core_reset, 0);
        chk("rerun_running", bus.running, 1);
        chk("rerun_ce", bus.ce_out, 0);
        // Shadow {5,5,1,0} became active at ALIGN
        exp_seq = '{4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b1111};
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("rerun%0d_ce", i), bus.ce_out, exp_seq[i]);
        end

        // Asynchronous reset between edges
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_ce", bus.ce_out, 0);
        chk("async_core_reset", bus.core_reset, 1);
        chk("async_running", bus.running, 0);
        #2;
        reset_n = 1'b1;
        wait_release(n_edges);
        chk("rst2_len", n_edges, 17);
        // Divisors back to defaults {5,3,1,0}
        exp_seq = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001, 4'b1011};
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("def%0d_ce", i), bus.ce_out, exp_seq[i]);
        end

        // MIN_RST=1 instance: one HOLD cycle, one ALIGN cycle
        chk("m1_pre_core_reset", bus1.core_reset, 0);
        bus1.reset_req = 1'b1;
        tick();
        bus1.reset_req = 1'b0;
        chk("m1_hold_core_reset", bus1.core_reset, 1);
        chk("m1_hold_running", bus1.running, 0);
        tick();
        chk("m1_align_core_reset", bus1.core_reset, 1);
        tick();
        chk("m1_run_core_reset", bus1.core_reset, 0);
        chk("m1_run_running", bus1.running, 1);
        tick();
        chk("m1_run1_ce", bus1.ce_out, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
